// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU (priority) plus FIFO-buffered load unit, with pending-write scoreboard.
// Optional macro WB_BYPASS_EN lets a B result skip the empty FIFO when the ALU is idle.
module regfile_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_rd,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_rd,
  input  logic [WIDTH-1:0] b_data,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] wdata,
  output logic [DEPTH-1:0] pending,
  output logic             fifo_full
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  logic [AW-1:0]    fifo_rd   [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;

  logic             bypass, push, pop, sel;
  logic [AW-1:0]    sel_rd;
  logic [WIDTH-1:0] sel_data;
  logic [DEPTH-1:0] pend_nxt;

  // b_ready comes straight from the registered count, keeping it free of input paths.
  assign b_ready   = (count != CNT_FULL);
  assign fifo_full = ~b_ready;

`ifdef WB_BYPASS_EN
  assign bypass = b_valid && !a_valid && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = b_valid && b_ready && !bypass;
  assign pop  = !a_valid && (count != '0);

  always_comb begin
    sel      = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (a_valid) begin
      sel      = 1'b1;
      sel_rd   = a_rd;
      sel_data = a_data;
    end else if (count != '0) begin
      sel      = 1'b1;
      sel_rd   = fifo_rd[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (bypass) begin
      sel      = 1'b1;
      sel_rd   = b_rd;
      sel_data = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= b_rd;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Set after clear so a re-issue to the register being written stays pending.
  always_comb begin
    pend_nxt = pending;
    if (we) pend_nxt[waddr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      pending <= '0;
    end else begin
      we      <= sel && (sel_rd != '0);
      pending <= pend_nxt;
      if (sel && (sel_rd != '0)) begin
        waddr <= sel_rd;
        wdata <= sel_data;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end for the 32×32 distributed-RAM register file. It merges two result producers into the file's single registered write port: the single-cycle ALU, which has priority, and the load/multi-cycle unit, which is buffered in a small FIFO. It also keeps a pending-write scoreboard that decode uses to stall on unresolved destinations. The block sits between the execute/memory stages and the register file's `we`/`waddr`/`wdata` inputs.

## Interface
- `WIDTH`, 32, data bits per register
- `DEPTH`, 32, number of architectural registers; `AW = $clog2(DEPTH)`
- `FIFO_DEPTH`, 4, source-B buffer entries; power of two, ≥2

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `a_valid`  in  1  ALU result valid; always accepted, no ready
- `a_rd`  in  AW  ALU destination register
- `a_data`  in  WIDTH  ALU result
- `b_valid`  in  1  load/multi-cycle result valid
- `b_ready`  out  1  B accepted on an edge where `b_valid && b_ready`
- `b_rd`  in  AW  B destination register
- `b_data`  in  WIDTH  B result
- `iss_valid`  in  1  an instruction with a destination issued this cycle
- `iss_rd`  in  AW  destination of the issued instruction
- `we`  out  1  register-file write enable (registered)
- `waddr`  out  AW  register-file write address (registered)
- `wdata`  out  WIDTH  register-file write data (registered)
- `pending`  out  DEPTH  scoreboard; bit r=1 means a write to r is outstanding
- `fifo_full`  out  1  B FIFO holds FIFO_DEPTH entries

## Operation
- FIFO: circular buffer with read/write pointers and a count (0..FIFO_DEPTH). `b_ready = (count != FIFO_DEPTH)`. `fifo_full` is the inverse of `b_ready`.
- Push on `b_valid && b_ready`. Pop when the FIFO head is selected. Push and pop may occur on the same edge, and then count is unchanged. The pointers wrap modulo FIFO_DEPTH.
- Selection each cycle, in priority order:
  - If `a_valid`, select A. The FIFO does not pop.
  - Else, if count ≠ 0, select the FIFO head and pop it.
  - Else, nothing is selected.
- Output register: on each edge, `we <= selected && (sel_rd != 0)`, `waddr <= sel_rd`, `wdata <= sel_data`. When `we` is 0, `waddr`/`wdata` hold their previous values.
- Writes to x0 are consumed (popped or accepted) but never drive `we`.
- Scoreboard, on each edge:
  - Clear `pending[waddr]` if `we` is 1 this cycle.
  - Then set `pending[iss_rd]` if `iss_valid && iss_rd != 0`. Set wins over a simultaneous clear on the same bit.
  - `pending[0]` is constant 0.
- Starvation of B under continuous `a_valid` is permitted; upstream guarantees ALU bubbles.
- Ordering: B results are written in acceptance order.

## Timing
- Reset, applied on any edge with `rst_n = 0`: `we=0`, `waddr=0`, `wdata=0`, `pending=0`, count=0, pointers=0, `b_ready=1`, `fifo_full=0`.
- Reset mid-operation discards all FIFO contents and pending bits. `we` is 0 from the first cycle after the reset edge.
- A latency: `a_valid` sampled at edge k gives `we=1` during cycle k..k+1. The register file captures the write at edge k+1.
- B latency, FIFO path: accepted at edge k; selected no earlier than cycle k..k+1; `we=1` in cycle k+1..k+2.
- `b_ready` depends only on registered count, with no combinational path from any input.
- Peak throughput: one write per cycle.

## Configuration
- `WB_BYPASS_EN` defined: when `b_valid`, `!a_valid` and count=0, B is selected directly. The transfer counts as accepted and nothing is pushed, so B latency equals A latency (1 edge to `we`).
- `WB_BYPASS_EN` undefined: every accepted B transfer goes through the FIFO, with a minimum of 2 edges to `we`.

## Test plan
- Reset, then `a_valid=1`, `a_rd=5`, `a_data=32'hDEADBEEF` for 1 cycle. Next cycle: `we=1`, `waddr=5`, `wdata=DEADBEEF`. Following cycle: `we=0`.
- Hold `a_valid=1` for 6 cycles while offering B rd=1..6 each cycle. B is accepted for 4 transfers, then `b_ready=0` and `fifo_full=1`. After A drops, `we` pulses for rd 1,2,3,4 on consecutive cycles in order, and `b_ready` returns to 1 after the first pop.
- B `rd=0`, data 32'h1234: `b_ready` handshake completes and `we` stays 0 throughout. With `iss_rd=0`, `pending` stays 0.
- `iss_valid`, `iss_rd=7`, so `pending[7]=1`. A write of rd=7 clears it in the cycle after `we=1`. On a cycle where `we=1` to rd 7 and `iss_rd=7` are simultaneous, `pending[7]` remains 1.
- Fill the FIFO with 3 entries, assert `rst_n=0` for 1 edge: `we=0`, `pending=0`, `b_ready=1`. Afterwards no stale entries are written.
- With `WB_BYPASS_EN`, the FIFO empty and `a_valid=0`: B rd=9 accepted at edge k gives `we=1`, `waddr=9` in the next cycle. Without the macro, the same write appears one cycle later.
